// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the arbitrated memory port.
//   mem_size_e     - access size encoding (BYTE/HALF/WORD/DWORD)
//   mem_rsp_t      - one entry of the response pipeline
//   align_mask     - offset bits that must be zero for an aligned access
//   lane_mask      - byte-enable vector for a store of a size at an offset
//   extract_extend - pick the addressed field out of a word and extend it
// Words are carried at 64 bits internally; 32-bit builds use the low half.
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } mem_size_e;

    typedef struct packed {
        logic        valid;
        logic        is_data;
        mem_size_e   size;
        logic        uns;
        logic [2:0]  offset;
        logic        err;
        logic [63:0] word;
    } mem_rsp_t;

    function automatic logic [2:0] align_mask(input mem_size_e size);
        case (size)
            BYTE:    return 3'b000;
            HALF:    return 3'b001;
            WORD:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input mem_size_e size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            BYTE:    base = 8'h01;
            HALF:    base = 8'h03;
            WORD:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    function automatic logic [63:0] extract_extend(input logic [63:0] word, input mem_size_e size,
                                                   input logic [2:0] offset, input logic uns);
        logic [63:0] sh;
        sh = word >> {offset, 3'b000};
        case (size)
            BYTE:    return {{56{~uns & sh[7]}},  sh[7:0]};
            HALF:    return {{48{~uns & sh[15]}}, sh[15:0]};
            WORD:    return {{32{~uns & sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// mem_rsp_pipe: fixed-latency response shift register.
//   clk, rst_n - clock, asynchronous active-low reset (clears valids only)
//   rsp_in     - response launched at the grant edge
//   rsp_out    - the same response STAGES cycles later
// Payload registers are not reset; only the valid chain is, so an
// in-flight response is dropped as soon as reset asserts.
module mem_rsp_pipe
    import mem_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  mem_rsp_t rsp_in,
    output mem_rsp_t rsp_out
);

    logic [STAGES:1] vld_pipe;
    mem_rsp_t        stg [1:STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rsp_in.valid;
            for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    always_ff @(posedge clk) begin
        stg[1] <= rsp_in;
        for (int s = 2; s <= STAGES; s++) stg[s] <= stg[s-1];
    end

    always_comb begin
        rsp_out       = stg[STAGES];
        rsp_out.valid = vld_pipe[STAGES];
    end

endmodule

// File: rtl/mem_arb_port.sv
// mem_arb_port: single RAM shared by an instruction-fetch port and a data
// port, one access per cycle, fixed-latency in-order responses.
//   i_req/i_addr -> i_gnt (comb), i_rvalid/i_rdata   : fetch port
//   d_req/d_we/d_size/d_unsigned/d_addr/d_wdata -> d_gnt (comb),
//   d_rvalid/d_rdata/d_err                           : data port
// Data has fixed priority; a fetch denied STARVE_LIMIT consecutive cycles
// is forced through on the next one.
// Optional: MEM_MISALIGN_TRAP_EN - misaligned data accesses return d_err
// and do not write. Without it, offsets are force-aligned to the size.
module mem_arb_port
    import mem_pkg::*;
#(
    parameter int    ADDR_WIDTH   = 12,
    parameter int    DATA_WIDTH   = 32,
    parameter int    READ_LATENCY = 1,
    parameter int    STARVE_LIMIT = 4,
    parameter string INIT_FILE    = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [31:0]           i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic                  d_unsigned,
    input  logic [31:0]           d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFFW   = $clog2(NBYTES);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int SCW    = $clog2(STARVE_LIMIT + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- arbitration ----------------
    logic [SCW-1:0] starve_cnt;
    logic           i_force;

    assign i_force = i_req && (starve_cnt == SCW'(STARVE_LIMIT));
    assign d_gnt   = d_req && !i_force;
    assign i_gnt   = i_req && (!d_req || i_force);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          starve_cnt <= '0;
        else if (i_gnt || !i_req)            starve_cnt <= '0;
        else if (starve_cnt != SCW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
    end

    // ---------------- data decode ----------------
    mem_size_e             dsz;
    logic [2:0]            d_off_raw, d_off, amask;
    logic [ADDR_WIDTH-1:0] d_idx, i_idx;
    logic [2:0]            i_off;
    logic                  illegal, misaligned, d_err_now, we_now;
    logic [7:0]            be_full;
    logic [NBYTES-1:0]     be;
    logic [DATA_WIDTH-1:0] wsh;

    assign dsz        = mem_size_e'(d_size);
    assign d_off_raw  = 3'(d_addr[OFFW-1:0]);
    assign d_idx      = d_addr[OFFW +: ADDR_WIDTH];
    assign amask      = align_mask(dsz);
    assign misaligned = |(d_off_raw & amask);
    assign illegal    = (dsz == DWORD) && (DATA_WIDTH == 32);

`ifdef MEM_MISALIGN_TRAP_EN
    assign d_err_now  = illegal || misaligned;
    assign d_off      = d_off_raw;
`else
    assign d_err_now  = illegal;
    assign d_off      = d_off_raw & ~amask;
`endif

    assign we_now  = d_gnt && d_we && !d_err_now;
    assign be_full = lane_mask(dsz, d_off);
    assign be      = be_full[NBYTES-1:0];
    assign wsh     = d_wdata << {d_off, 3'b000};

    // Fetch always reads a 32-bit slot; on 64-bit words i_addr[2] picks the half.
    assign i_idx = i_addr[OFFW +: ADDR_WIDTH];
    assign i_off = 3'(i_addr[OFFW-1:0]) & 3'b100;

    always_ff @(posedge clk) begin
        if (we_now)
            for (int b = 0; b < NBYTES; b++)
                if (be[b]) mem[d_idx][b*8 +: 8] <= wsh[b*8 +: 8];
    end

    // ---------------- response launch ----------------
    mem_rsp_t rsp_in, rsp_out;

    // Stores and errored accesses carry a zero word so the output stage
    // naturally returns rdata=0 for them.
    always_comb begin
        rsp_in = '0;
        if (d_gnt) begin
            rsp_in.valid   = 1'b1;
            rsp_in.is_data = 1'b1;
            rsp_in.size    = dsz;
            rsp_in.uns     = d_unsigned;
            rsp_in.offset  = d_off;
            rsp_in.err     = d_err_now;
            rsp_in.word    = (d_we || d_err_now) ? '0 : 64'(mem[d_idx]);
        end else if (i_gnt) begin
            rsp_in.valid   = 1'b1;
            rsp_in.size    = WORD;
            rsp_in.uns     = 1'b1;
            rsp_in.offset  = i_off;
            rsp_in.word    = 64'(mem[i_idx]);
        end
    end

    mem_rsp_pipe #(.STAGES(READ_LATENCY)) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .rsp_in  (rsp_in),
        .rsp_out (rsp_out)
    );

    // ---------------- output stage ----------------
    logic [63:0] ext;

    assign ext      = extract_extend(rsp_out.word, rsp_out.size, rsp_out.offset, rsp_out.uns);
    assign d_rvalid = rsp_out.valid && rsp_out.is_data;
    assign i_rvalid = rsp_out.valid && !rsp_out.is_data;
    assign d_rdata  = d_rvalid ? ext[DATA_WIDTH-1:0] : '0;
    assign i_rdata  = i_rvalid ? ext[31:0] : '0;
    assign d_err    = d_rvalid && rsp_out.err;

    // Address bits above the word index and spare lane/extension bits are ignored.
    logic unused;
    assign unused = ^{d_addr, i_addr, be_full, ext};

endmodule

// File: tb/tb_mem_arb_port.sv
module tb_mem_arb_port;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int SL  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [31:0]   i_addr = '0;
    logic          i_gnt, i_rvalid;
    logic [31:0]   i_rdata;
    logic          d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
    logic [1:0]    d_size = '0;
    logic [31:0]   d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid, d_err;
    logic [DW-1:0] d_rdata;

    mem_arb_port #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT),
        .STARVE_LIMIT(SL), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_data;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   rsp_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input bit is_d, input logic [31:0] data, input logic err);
        exp_t e;
        e.is_data = is_d;
        e.data    = data;
        e.err     = err;
        e.cyc     = cyc + LAT;
        sbq.push_back(e);
    endtask

    // Monitor: every response the DUT presents is popped and compared.
    always @(negedge clk) begin
        if (rst_n && (d_rvalid || i_rvalid)) begin
            exp_t        e;
            logic [31:0] act;
            rsp_seen++;
            checks++;
            act = d_rvalid ? d_rdata : i_rdata;
            if (d_rvalid && i_rvalid) begin
                errors++;
                $display("FAIL dual_rvalid: actual=both ports valid at cycle %0d required=one", cyc);
            end else if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: actual d=%b i=%b data=%h at cycle %0d required=no response",
                         d_rvalid, i_rvalid, act, cyc);
            end else begin
                e = sbq.pop_front();
                if (e.is_data != d_rvalid || e.data !== act || e.err !== d_err || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL rsp: actual d=%b data=%h err=%b cyc=%0d required d=%b data=%h err=%b cyc=%0d",
                             d_rvalid, act, d_err, cyc, e.is_data, e.data, e.err, e.cyc);
                end
            end
        end
    end

    task automatic d_op(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        bit got = 0;
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd;
        for (int k = 0; k < 8 && !got; k++) begin
            #1;
            if (d_gnt) begin
                got = 1;
                push(1'b1, exp_d, exp_e);
            end
            @(posedge clk);
        end
        #1 d_req = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL d_gnt_timeout: actual=no grant required=grant for addr %h", a);
        end
    endtask

    task automatic i_op(input logic [31:0] a, input logic [31:0] exp_d);
        bit got = 0;
        @(negedge clk);
        i_req = 1'b1; i_addr = a;
        for (int k = 0; k < 8 && !got; k++) begin
            #1;
            if (i_gnt) begin
                got = 1;
                push(1'b0, exp_d, 1'b0);
            end
            @(posedge clk);
        end
        #1 i_req = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL i_gnt_timeout: actual=no grant required=grant for addr %h", a);
        end
    endtask

    initial begin
        int seen0;

        // reset state
        repeat (2) @(negedge clk);
        i_req = 1'b1;
        #1;
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_rdata",  d_rdata, 0);
        chk("rst_i_rdata",  i_rdata, 0);
        chk("rst_d_err",    d_err, 0);
        chk("rst_i_gnt_comb", i_gnt, 1);
        @(negedge clk);
        i_req = 1'b0;
        rst_n = 1'b1;

        // byte-lane merge
        d_op(1, 2, 0, 32'h40, 32'h11223344, 0, 0);
        d_op(1, 0, 0, 32'h42, 32'h000000AA, 0, 0);
        d_op(0, 2, 0, 32'h40, 0, 32'h11AA3344, 0);

        // extension
        d_op(1, 2, 0, 32'h80, 32'h80FF7F01, 0, 0);
        d_op(0, 0, 0, 32'h81, 0, 32'h0000007F, 0);
        d_op(0, 0, 0, 32'h83, 0, 32'hFFFFFF80, 0);
        d_op(0, 1, 1, 32'h82, 0, 32'h000080FF, 0);
        d_op(0, 1, 0, 32'h82, 0, 32'hFFFF80FF, 0);
        d_op(0, 0, 1, 32'h83, 0, 32'h00000080, 0);

        // fetch ignores addr[1:0]
        i_op(32'h43, 32'h11AA3344);
        i_op(32'h82, 32'h80FF7F01);

        // starvation: fetch forced through on cycle 5, then data wins again
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_size = 2; d_unsigned = 1'b0; d_addr = 32'h80;
        i_req = 1'b1; i_addr = 32'h40;
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk($sformatf("starve_d_gnt_c%0d", k), d_gnt, (k != 5));
            chk($sformatf("starve_i_gnt_c%0d", k), i_gnt, (k == 5));
            if (d_gnt) push(1'b1, 32'h80FF7F01, 1'b0);
            if (i_gnt) push(1'b0, 32'h11AA3344, 1'b0);
            @(negedge clk);
        end
        d_req = 1'b0; i_req = 1'b0;

        // illegal size on a 32-bit build: error, no write
        d_op(1, 3, 0, 32'h80, 32'hDEADBEEF, 0, 1);
        d_op(0, 2, 1, 32'h80, 0, 32'h80FF7F01, 0);

        // misalignment
`ifdef MEM_MISALIGN_TRAP_EN
        d_op(1, 1, 0, 32'h41, 32'h0000BEEF, 0, 1);
        d_op(0, 2, 0, 32'h40, 0, 32'h11AA3344, 0);
        d_op(0, 1, 0, 32'h41, 0, 0, 1);
`else
        d_op(1, 1, 0, 32'h41, 32'h0000BEEF, 0, 0);
        d_op(0, 2, 0, 32'h40, 0, 32'h11AABEEF, 0);
        d_op(0, 1, 0, 32'h41, 0, 32'hFFFFBEEF, 0);
`endif

        // wrap modulo depth
        d_op(1, 2, 0, 32'h4000, 32'hCAFEF00D, 0, 0);
        d_op(0, 2, 0, 32'h0000, 0, 32'hCAFEF00D, 0);

        // reset mid-flight: granted load and pending fetch are discarded
        repeat (LAT + 2) @(negedge clk);
        seen0 = rsp_seen;
        d_req = 1'b1; d_we = 1'b0; d_size = 2; d_addr = 32'h80;
        i_req = 1'b1; i_addr = 32'h40;
        #1;
        chk("rst_flight_d_gnt", d_gnt, 1);
        @(posedge clk);
        #1 d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        chk("rst_flight_starve_cnt", dut.starve_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        chk("rst_flight_no_rsp", rsp_seen - seen0, 0);

        // array survives reset
        d_op(0, 2, 0, 32'h80, 0, 32'h80FF7F01, 0);

        repeat (LAT + 3) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
